// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: control FSM for a bit-serial adder.
//
// Sequences a WIDTH-bit serial add through IDLE -> LOAD -> SHIFT (WIDTH
// cycles) -> DONE. The datapath operand shift registers, the carry flop and
// the full adder sit outside this block. This block drives reset / load /
// enable into that datapath and captures the final carry-out into cout.
//
// Optional build macro:
//   SERIAL_ADD_ABORT_EN - adds an 'abort' input. abort=1 in LOAD or SHIFT
//                         drops the add and returns to IDLE without a done
//                         pulse, leaving cout untouched.
module serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             carry_nxt,
`ifdef SERIAL_ADD_ABORT_EN
  input  logic             abort,
`endif
  output logic             reset,
  output logic             load,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic             cout,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Index of the last bit; SHIFT leaves when the counter reaches it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cout_q;
  logic             cout_nxt;
  logic             abort_req;

`ifdef SERIAL_ADD_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // State, bit counter and captured carry; resetn clears all three.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt_q  <= CNT_ZERO;
      cout_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt_q  <= cnt_nxt;
      cout_q <= cout_nxt;
    end
  end

  // Next-state, counter and carry-capture logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = CNT_ZERO;
    cout_nxt  = cout_q;
    case (state)
      IDLE: begin
        // start is only looked at here; it is ignored in every other state.
        if (start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        // Counter is already zero, so SHIFT begins on bit 0.
        if (abort_req) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (abort_req) begin
          // Dropped add: carry from the partial sum is not reported.
          state_nxt = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Last bit: carry_nxt is the final carry-out of the whole add.
          state_nxt = DONE;
          cout_nxt  = carry_nxt;
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath controls are decoded from the registered state only, so no
  // input reaches these outputs combinationally.
  always_comb begin
    reset  = 1'b0;
    load   = 1'b0;
    enable = 1'b0;
    busy   = 1'b1;
    done   = 1'b0;
    case (state)
      IDLE: begin
        reset = 1'b1;
        busy  = 1'b0;
      end
      LOAD: begin
        reset = 1'b1;
        load  = 1'b1;
      end
      SHIFT: begin
        enable = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        reset = 1'b1;
        busy  = 1'b0;
      end
    endcase
  end

  assign cnt  = cnt_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed bench for serial_add_ctrl at WIDTH=8.
// Build with SERIAL_ADD_ABORT_EN defined to include the abort sequences.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  // Output decode {reset, load, enable, busy, done} per state.
  localparam logic [4:0] O_IDLE  = 5'b10000;
  localparam logic [4:0] O_LOAD  = 5'b11010;
  localparam logic [4:0] O_SHIFT = 5'b00110;
  localparam logic [4:0] O_DONE  = 5'b00011;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       carry_nxt;
`ifdef SERIAL_ADD_ABORT_EN
  logic       abort;
`endif
  logic       reset;
  logic       load;
  logic       enable;
  logic       busy;
  logic       done;
  logic       cout;
  logic [2:0] cnt;

  int n_vec = 0;
  int n_err = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .carry_nxt (carry_nxt),
`ifdef SERIAL_ADD_ABORT_EN
    .abort     (abort),
`endif
    .reset     (reset),
    .load      (load),
    .enable    (enable),
    .busy      (busy),
    .done      (done),
    .cout      (cout),
    .cnt       (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       carry;
    logic [4:0] dec;
    logic       cout;
    int         cnt;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [4:0] dec, input logic co,
                     input int c);
    logic [8:0] act;
    logic [8:0] exp;
    act = {reset, load, enable, busy, done, cout, cnt};
    exp = {dec, co, 3'(c)};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: {rst,ld,en,bsy,dn,co}=%b cnt=%0d, expected %b cnt=%0d",
               nm, act[8:3], act[2:0], exp[8:3], exp[2:0]);
    end
  endtask

  // One complete add from IDLE. Non-final bits drive the opposite carry so a
  // capture on the wrong cycle shows up in cout.
  task automatic run_add(input string nm, input logic cf, input logic prev);
    start = 1'b1;
    chk({nm, "_idle"}, O_IDLE, prev, 0);
    tick();
    start = 1'b0;
    chk({nm, "_load"}, O_LOAD, prev, 0);
    tick();
    for (int i = 0; i < WIDTH; i++) begin
      carry_nxt = (i == WIDTH - 1) ? cf : ~cf;
      chk($sformatf("%s_shift%0d", nm, i), O_SHIFT, prev, i);
      tick();
    end
    carry_nxt = 1'b0;
    chk({nm, "_done"}, O_DONE, cf, 0);
    tick();
    chk({nm, "_after"}, O_IDLE, cf, 0);
  endtask

  initial begin
    // Single add: start pulse in cycle 0, a stray start in SHIFT and in
    // DONE, carry_nxt=1 mid-add and in the final bit.
    tbl[0]  = '{1'b1, 1'b0, O_IDLE,  1'b0, 0};
    tbl[1]  = '{1'b0, 1'b0, O_LOAD,  1'b0, 0};
    tbl[2]  = '{1'b0, 1'b0, O_SHIFT, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0, O_SHIFT, 1'b0, 1};
    tbl[4]  = '{1'b0, 1'b0, O_SHIFT, 1'b0, 2};
    tbl[5]  = '{1'b0, 1'b1, O_SHIFT, 1'b0, 3};
    tbl[6]  = '{1'b0, 1'b0, O_SHIFT, 1'b0, 4};
    tbl[7]  = '{1'b0, 1'b0, O_SHIFT, 1'b0, 5};
    tbl[8]  = '{1'b0, 1'b0, O_SHIFT, 1'b0, 6};
    tbl[9]  = '{1'b0, 1'b1, O_SHIFT, 1'b0, 7};
    tbl[10] = '{1'b1, 1'b0, O_DONE,  1'b1, 0};
    tbl[11] = '{1'b0, 1'b0, O_IDLE,  1'b1, 0};
    tbl[12] = '{1'b0, 1'b0, O_IDLE,  1'b1, 0};

    resetn    = 1'b0;
    start     = 1'b1;
    carry_nxt = 1'b1;
`ifdef SERIAL_ADD_ABORT_EN
    abort     = 1'b0;
`endif
    tick();
    tick();
    chk("reset_state", O_IDLE, 1'b0, 0);
    resetn    = 1'b1;
    start     = 1'b0;
    carry_nxt = 1'b0;
    tick();
    chk("post_reset_idle", O_IDLE, 1'b0, 0);

    for (int k = 0; k < 13; k++) begin
      start     = tbl[k].start;
      carry_nxt = tbl[k].carry;
      chk($sformatf("tbl_cyc%0d", k), tbl[k].dec, tbl[k].cout, tbl[k].cnt);
      tick();
    end
    start     = 1'b0;
    carry_nxt = 1'b0;

    // Next add clears cout; the one after sets it again.
    run_add("add_c0", 1'b0, 1'b1);
    run_add("add_c1", 1'b1, 1'b0);

    // Reset for two cycles with the counter at 3.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("rst_mid_cnt3", O_SHIFT, 1'b1, 3);
    resetn    = 1'b0;
    carry_nxt = 1'b1;
    tick();
    chk("rst_cyc1", O_IDLE, 1'b0, 0);
    tick();
    chk("rst_cyc2", O_IDLE, 1'b0, 0);
    resetn    = 1'b1;
    carry_nxt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("rst_nodone%0d", i), O_IDLE, 1'b0, 0);
      tick();
    end

    // start held for 30 cycles: adds every WIDTH+3 cycles.
    for (int c = 0; c < 34; c++) begin
      int         p;
      logic [4:0] d;
      int         ec;
      start = (c < 30);
      p  = c % (WIDTH + 3);
      ec = 0;
      if (p == 0) d = O_IDLE;
      else if (p == 1) d = O_LOAD;
      else if (p == WIDTH + 2) d = O_DONE;
      else begin
        d  = O_SHIFT;
        ec = p - 2;
      end
      chk($sformatf("held_cyc%0d", c), d, 1'b0, ec);
      tick();
    end
    start = 1'b0;

`ifdef SERIAL_ADD_ABORT_EN
    run_add("pre_abort", 1'b1, 1'b0);
    // Abort at cnt=4 with carry_nxt high: cout must stay 1, no done.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("abort_cnt4", O_SHIFT, 1'b1, 4);
    abort     = 1'b1;
    carry_nxt = 1'b1;
    tick();
    chk("abort_to_idle", O_IDLE, 1'b1, 0);
    abort     = 1'b0;
    carry_nxt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("abort_nodone%0d", i), O_IDLE, 1'b1, 0);
      tick();
    end
    // Abort in IDLE is ignored; abort in LOAD returns to IDLE.
    abort = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_idle_ignored", O_LOAD, 1'b1, 0);
    tick();
    chk("abort_in_load", O_IDLE, 1'b1, 0);
    abort = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, giving the operand bit count per add (legal range 2..64).
REQ-002 SHALL define CNT_W = $clog2(WIDTH) as a local parameter, giving the bit-counter width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 resetn  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  request a new add; sampled only in IDLE.
REQ-006 carry_nxt  input  1  combinational carry-out of the datapath full adder for the current bit.
REQ-007 reset  output  1  clears the datapath carry flop.
REQ-008 load  output  1  parallel-loads the datapath operand shift registers.
REQ-009 enable  output  1  shifts the datapath one bit and updates its carry flop.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse marking a completed add.
REQ-012 cout  output  1  final carry-out of the last completed add.
REQ-013 cnt  output  CNT_W  index of the bit being shifted.

Function
REQ-014 SHALL implement states IDLE, LOAD, SHIFT and DONE.
REQ-015 Decode in IDLE SHALL be reset=1, load=0, enable=0.
REQ-016 Decode in LOAD SHALL be reset=1, load=1, enable=0.
REQ-017 Decode in SHIFT SHALL be reset=0, load=0, enable=1.
REQ-018 Decode in DONE SHALL be reset=0, load=0, enable=0, done=1.
REQ-019 reset, load, enable, busy and done SHALL be pure decodes of the registered state, with no input-to-output combinational path.
REQ-020 IDLE SHALL go to LOAD when start=1 and otherwise stay in IDLE.
REQ-021 LOAD SHALL last exactly one cycle, then go to SHIFT, regardless of start.
REQ-022 SHIFT SHALL last exactly WIDTH cycles; cnt SHALL be 0 on entry and increment by 1 per cycle.
REQ-023 When cnt==WIDTH-1 in SHIFT, the next state SHALL be DONE and cnt SHALL return to 0, with no wrap past WIDTH-1.
REQ-024 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-025 Latency from the edge sampling start=1 in IDLE to the done pulse SHALL be WIDTH+2 cycles.
REQ-026 Back-to-back adds SHALL have a minimum period of WIDTH+3 cycles.
REQ-027 start SHALL be ignored in LOAD, SHIFT and DONE; a start held high through DONE SHALL launch the next add from IDLE one cycle later.
REQ-028 cout SHALL register carry_nxt on the edge leaving the final SHIFT cycle, be valid with done, and hold until the next final SHIFT cycle.
REQ-029 cnt SHALL read 0 outside SHIFT.

Reset
REQ-030 When resetn=0 at a clock edge, state SHALL become IDLE, cnt SHALL become 0, and cout SHALL become 0.
REQ-031 Resulting output values after reset SHALL be reset=1, load=0, enable=0, busy=0 and done=0.
REQ-032 Reset SHALL take priority over start and over any in-progress add, including mid-SHIFT; no done pulse SHALL be produced for an aborted add.
REQ-033 Reset SHALL have no effect between clock edges.

Configuration
REQ-034 With SERIAL_ADD_ABORT_EN defined, an input port abort (1 bit) SHALL be present.
REQ-035 With SERIAL_ADD_ABORT_EN defined, abort=1 in LOAD or SHIFT SHALL force next state IDLE and cnt=0, with cout unchanged and no done pulse.
REQ-036 With SERIAL_ADD_ABORT_EN defined, abort SHALL be ignored in IDLE and DONE.
REQ-037 With SERIAL_ADD_ABORT_EN defined, resetn=0 SHALL still win over abort.
REQ-038 Without SERIAL_ADD_ABORT_EN, the abort port SHALL be absent and behaviour SHALL be as REQ-014..REQ-029.

Verification
REQ-039 Reset: resetn=0 for 2 cycles mid-SHIFT (cnt=3) -> IDLE, reset=1, busy=0, cnt=0, cout=0, and no done pulse.
REQ-040 Single add, WIDTH=8: start pulse at cycle 0 -> load=1 at cycle 1, enable=1 at cycles 2..9 with cnt 0..7, done=1 at cycle 10, busy=0 at cycle 11.
REQ-041 Carry capture: carry_nxt=1 only in the final SHIFT cycle -> cout=1 with done.
REQ-042 Carry capture: the next add with carry_nxt=0 in its final SHIFT cycle -> cout=0.
REQ-043 Held start: start=1 continuously for 30 cycles -> done pulses at cycles 10 and 21, with no LOAD re-entry during SHIFT.
REQ-044 Abort (SERIAL_ADD_ABORT_EN defined): abort=1 at cnt=4 -> IDLE next cycle, no done pulse, and cout holds its prior value.
